// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential fetch, in-order response FIFO, redirect flush.
// Optional PREFETCH_STATS_EN adds saturating redirect/discard counters.
module inst_prefetch_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_PC = '0,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PC_STEP = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [DATA_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    output logic [DATA_WIDTH-1:0]     inst_out,
    output logic [DATA_WIDTH-1:0]     inst_pc,
    output logic                      inst_valid,
    input  logic                      inst_ready,
    input  logic                      redirect_valid,
    input  logic [DATA_WIDTH-1:0]     redirect_pc,
`ifdef PREFETCH_STATS_EN
    output logic [31:0]               redirect_count,
    output logic [31:0]               discard_count,
`endif
    output logic [$clog2(DEPTH):0]    outstanding
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LIVE_W = CNT_W + 1;

    localparam logic [1:0] ST_FETCH    = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]      out_q, out_d;
    logic [CNT_W-1:0]      disc_q, disc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      pend_wr_q, pend_wr_d;
    logic [PTR_W-1:0]      pend_rd_q, pend_rd_d;

    logic [DATA_WIDTH-1:0] fifo_data [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] pend_pc   [DEPTH];

    logic [LIVE_W-1:0]     live, live_d;
    logic                  can_req, fire, drop, wr, pop;

    // Credit: live entries bounded by DEPTH; total in flight (incl. stale) also capped
    // so the pending-PC queue and the outstanding counter never overflow.
    always_comb begin
        live    = LIVE_W'(cnt_q) + LIVE_W'(out_q - disc_q);
        can_req = (state_q == ST_FETCH) && (live < LIVE_W'(DEPTH)) && (out_q < CNT_W'(DEPTH));
        mem_req_valid = rst_n && can_req;
        fire    = mem_req_valid && mem_req_ready;
        drop    = mem_rsp_valid && (redirect_valid || (disc_q != '0));
        wr      = mem_rsp_valid && !drop;
        inst_valid = (cnt_q != '0);
        pop     = inst_valid && inst_ready;
        mem_req_addr = fetch_pc_q;
        inst_out     = inst_valid ? fifo_data[rd_ptr_q] : '0;
        inst_pc      = inst_valid ? fifo_pc[rd_ptr_q]   : '0;
        outstanding  = out_q;
    end

    // Next-state: redirect overrides FIFO/discard/PC updates of the same cycle.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q + CNT_W'(fire) - CNT_W'(mem_rsp_valid);
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        pend_wr_d  = fire ? pend_wr_q + PTR_W'(1) : pend_wr_q;
        pend_rd_d  = mem_rsp_valid ? pend_rd_q + PTR_W'(1) : pend_rd_q;
        live_d     = '0;

        if (fire) begin
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_STEP);
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            disc_d     = out_d;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            state_d    = ST_REDIRECT;
        end else begin
            if (mem_rsp_valid && (disc_q != '0)) begin
                disc_d = disc_q - CNT_W'(1);
            end
            if (wr) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            cnt_d   = cnt_q + CNT_W'(wr) - CNT_W'(pop);
            live_d  = LIVE_W'(cnt_d) + LIVE_W'(out_d - disc_d);
            state_d = (live_d >= LIVE_W'(DEPTH)) ? ST_HOLD : ST_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= INIT_PC;
            out_q      <= '0;
            disc_q     <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pend_wr_q  <= '0;
            pend_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pend_wr_q  <= pend_wr_d;
            pend_rd_q  <= pend_rd_d;
        end
    end

    // Storage arrays; contents are only observed while the matching count is non-zero.
    always_ff @(posedge clk) begin
        if (fire) begin
            pend_pc[pend_wr_q] <= fetch_pc_q;
        end
        if (wr) begin
            fifo_data[wr_ptr_q] <= mem_rsp_data;
            fifo_pc[wr_ptr_q]   <= pend_pc[pend_rd_q];
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [31:0] redir_cnt_q, disc_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redir_cnt_q <= '0;
            disc_cnt_q  <= '0;
        end else begin
            if (redirect_valid && (redir_cnt_q != '1)) begin
                redir_cnt_q <= redir_cnt_q + 32'd1;
            end
            if (drop && (disc_cnt_q != '1)) begin
                disc_cnt_q <= disc_cnt_q + 32'd1;
            end
        end
    end

    assign redirect_count = redir_cnt_q;
    assign discard_count  = disc_cnt_q;
`endif

endmodule
